// File: rtl/fwrisc_decode_bench_env.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_decode_bench_env
//  Purpose  : Bench-side environment wrapped around the fwrisc decode stage.
//             Sequences the DUT reset, models an N-port register file with a
//             configurable read latency, returns exec_complete a configurable
//             number of cycles after an op is accepted, counts completed and
//             fetched instructions, and flags decode-handshake violations.
//  Ports    : clock           - bench clock
//             reset           - asynchronous active-low bench reset
//             dut_reset       - synchronous active-high reset for the DUT
//             fetch_valid     - instruction valid from the test driver
//             decode_complete - decode stage accepted the instruction
//             rf_raddr        - packed register read addresses (port 0 LSBs)
//             rf_rdata        - packed register read data (port 0 LSBs)
//             decode_valid    - decoded operation presented to execute
//             exec_complete   - one-cycle execute-done pulse
//             instr_count     - exec_complete pulses since reset (wrapping)
//             fetch_count     - fetch accept cycles since reset (wrapping)
//             proto_err       - sticky handshake-violation flag
//             lfsr_state      - LFSR trace output (optional feature only)
//  Options  : FWRISC_BENCH_RAND_LAT_EN - when defined, the execute latency is
//             drawn from a 16-bit LFSR (1..EXEC_LATENCY) and lfsr_state is
//             added to the port list. Undefined: fixed EXEC_LATENCY.
//  Revision : 1.0 - initial release
// ============================================================================
module fwrisc_decode_bench_env #(
   parameter int XLEN         = 32,
   parameter int RADDR_W      = 6,
   parameter int NUM_RD_PORTS = 2,
   parameter int RD_LATENCY   = 1,
   parameter int EXEC_LATENCY = 1,
   parameter int RESET_CYCLES = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   output logic                             dut_reset,
   input  logic                             fetch_valid,
   input  logic                             decode_complete,
   input  logic [NUM_RD_PORTS*RADDR_W-1:0]  rf_raddr,
   output logic [NUM_RD_PORTS*XLEN-1:0]     rf_rdata,
   input  logic                             decode_valid,
   output logic                             exec_complete,
   output logic [31:0]                      instr_count,
   output logic [31:0]                      fetch_count,
   output logic                             proto_err
`ifdef FWRISC_BENCH_RAND_LAT_EN
   ,
   output logic [15:0]                      lfsr_state
`endif
);

   localparam logic [3:0] c_reset_cycles = 4'(RESET_CYCLES);
   localparam logic [3:0] c_lat_init     = 4'(EXEC_LATENCY - 1);

   // ------------------------------------------------------------------------
   // Reset sequencing: dut_reset falls on the edge where the counter reaches
   // RESET_CYCLES; counting stops afterwards so the counter never wraps.
   // ------------------------------------------------------------------------
   logic [3:0] r_rst_cnt;
   logic [3:0] w_rst_cnt_nxt;
   logic       r_dut_reset;

   assign w_rst_cnt_nxt = r_rst_cnt + 4'd1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rst_cnt   <= 4'd0;
         r_dut_reset <= 1'b1;
      end else if (r_dut_reset) begin
         r_rst_cnt <= w_rst_cnt_nxt;
         if (w_rst_cnt_nxt == c_reset_cycles) begin
            r_dut_reset <= 1'b0;
         end
      end
   end

   assign dut_reset = r_dut_reset;

   // ------------------------------------------------------------------------
   // Register file model: each port returns its own address zero-extended,
   // delayed by RD_LATENCY stages.
   // ------------------------------------------------------------------------
   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      logic [XLEN-1:0] w_zext;
      assign w_zext = XLEN'(rf_raddr[p*RADDR_W +: RADDR_W]);

      if (RD_LATENCY == 0) begin : g_comb
         // Combinational path, still forced to zero while reset is held.
         assign rf_rdata[p*XLEN +: XLEN] = reset ? w_zext : '0;
      end else begin : g_pipe
         logic [XLEN-1:0] r_stage [RD_LATENCY];

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int s = 0; s < RD_LATENCY; s++) begin
                  r_stage[s] <= '0;
               end
            end else begin
               r_stage[0] <= w_zext;
               for (int s = 1; s < RD_LATENCY; s++) begin
                  r_stage[s] <= r_stage[s-1];
               end
            end
         end

         assign rf_rdata[p*XLEN +: XLEN] = r_stage[RD_LATENCY-1];
      end
   end

   // ------------------------------------------------------------------------
   // Latency value loaded on accept: fixed, or LFSR-drawn.
   // ------------------------------------------------------------------------
   logic [3:0] w_lat_load;

`ifdef FWRISC_BENCH_RAND_LAT_EN
   localparam logic [3:0] c_exec_lat = 4'(EXEC_LATENCY);

   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end

   assign w_lat_load = r_lfsr[3:0] % c_exec_lat;
   assign lfsr_state = r_lfsr;
`else
   assign w_lat_load = c_lat_init;
`endif

   // ------------------------------------------------------------------------
   // Execute FSM
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ACK   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_lat_cnt;
   logic [3:0] w_lat_cnt_nxt;
   logic       w_withdraw;
   logic       r_exec_complete;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_lat_cnt       <= 4'd0;
         r_exec_complete <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_lat_cnt       <= w_lat_cnt_nxt;
         // Registered Moore output: high for exactly the ACK cycle.
         r_exec_complete <= (w_state_nxt == ST_ACK);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_lat_cnt_nxt = r_lat_cnt;
      w_withdraw    = 1'b0;
      if (r_dut_reset) begin
         w_state_nxt   = ST_IDLE;
         w_lat_cnt_nxt = 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (decode_valid) begin
                  w_lat_cnt_nxt = w_lat_load;
                  w_state_nxt   = (w_lat_load == 4'd0) ? ST_ACK : ST_BUSY;
               end
            end
            ST_BUSY: begin
               w_lat_cnt_nxt = r_lat_cnt - 4'd1;
               // Leaving when the decremented count hits zero.
               if (r_lat_cnt <= 4'd1) begin
                  w_state_nxt = ST_ACK;
               end
               // Op withdrawn before completion; execution still finishes.
               w_withdraw = ~decode_valid;
            end
            ST_ACK: begin
               w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
               // decode_valid is ignored here to cover the decoder drop delay.
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign exec_complete = r_exec_complete;

   // ------------------------------------------------------------------------
   // Counters and protocol checking (inactive while dut_reset is high)
   // ------------------------------------------------------------------------
   logic [31:0] r_instr_count;
   logic [31:0] r_fetch_count;
   logic        r_proto_err;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_instr_count <= 32'd0;
         r_fetch_count <= 32'd0;
         r_proto_err   <= 1'b0;
      end else if (r_dut_reset) begin
         r_instr_count <= 32'd0;
         r_fetch_count <= 32'd0;
         r_proto_err   <= 1'b0;
      end else begin
         if (r_state == ST_ACK) begin
            r_instr_count <= r_instr_count + 32'd1;
         end
         if (fetch_valid && decode_complete) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if (w_withdraw || (decode_complete && !fetch_valid)) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign instr_count = r_instr_count;
   assign fetch_count = r_fetch_count;
   assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_decode_bench_env.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwrisc_decode_bench_env
//  Purpose  : Self-checking bench for fwrisc_decode_bench_env. Two instances:
//             the main one (RD_LATENCY=1, EXEC_LATENCY=3, RESET_CYCLES=2) and
//             a combinational-read one (RD_LATENCY=0) sharing clock, reset and
//             read addresses. Stimulus pushes expectations into queues; a
//             monitor on the falling edge pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwrisc_decode_bench_env;

   localparam int XLEN     = 32;
   localparam int RADDR_W  = 6;
   localparam int NP       = 2;
   localparam int EXEC_LAT = 3;
   localparam int RST_CYC  = 2;

   localparam int K_DRST   = 0;
   localparam int K_INSTR  = 1;
   localparam int K_FETCH  = 2;
   localparam int K_PROTO  = 3;
   localparam int K_EXEC   = 4;
   localparam int K_RD1    = 5;
   localparam int K_RD0    = 6;
   localparam int K_DRST0  = 7;
   localparam int K_INSTR0 = 8;
   localparam int K_FETCH0 = 9;
   localparam int K_PROTO0 = 10;
   localparam int K_EXEC0  = 11;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    fetch_valid;
   logic                    decode_complete;
   logic                    decode_valid;
   logic [NP*RADDR_W-1:0]   rf_raddr;

   logic                    dut_reset, exec_complete, proto_err;
   logic [NP*XLEN-1:0]      rf_rdata;
   logic [31:0]             instr_count, fetch_count;

   logic                    dut_reset0, exec_complete0, proto_err0;
   logic [NP*XLEN-1:0]      rf_rdata0;
   logic [31:0]             instr_count0, fetch_count0;

   always #5 clock = ~clock;

   fwrisc_decode_bench_env #(
      .XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_RD_PORTS(NP), .RD_LATENCY(1),
      .EXEC_LATENCY(EXEC_LAT), .RESET_CYCLES(RST_CYC)
   ) u_dut (
      .clock(clock), .reset(reset), .dut_reset(dut_reset),
      .fetch_valid(fetch_valid), .decode_complete(decode_complete),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .decode_valid(decode_valid),
      .exec_complete(exec_complete), .instr_count(instr_count),
      .fetch_count(fetch_count), .proto_err(proto_err)
   );

   fwrisc_decode_bench_env #(
      .XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_RD_PORTS(NP), .RD_LATENCY(0),
      .EXEC_LATENCY(EXEC_LAT), .RESET_CYCLES(RST_CYC)
   ) u_dut_rd0 (
      .clock(clock), .reset(reset), .dut_reset(dut_reset0),
      .fetch_valid(1'b0), .decode_complete(1'b0),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata0), .decode_valid(1'b0),
      .exec_complete(exec_complete0), .instr_count(instr_count0),
      .fetch_count(fetch_count0), .proto_err(proto_err0)
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { int cyc; logic [31:0] cnt; } exec_exp_t;
   typedef struct { int kind; int cyc; logic [63:0] val; } chk_t;

   exec_exp_t exec_q[$];
   chk_t      chk_q[$];
   int        total = 0;
   int        bad   = 0;
   bit        done  = 1'b0;
   logic [31:0] exp_instr = 32'd0;
   logic [31:0] exp_fetch = 32'd0;

   function automatic logic [63:0] sample(input int k);
      logic [63:0] v;
      v = '0;
      case (k)
         K_DRST:   v = 64'(dut_reset);
         K_INSTR:  v = 64'(instr_count);
         K_FETCH:  v = 64'(fetch_count);
         K_PROTO:  v = 64'(proto_err);
         K_EXEC:   v = 64'(exec_complete);
         K_RD1:    v = rf_rdata;
         K_RD0:    v = rf_rdata0;
         K_DRST0:  v = 64'(dut_reset0);
         K_INSTR0: v = 64'(instr_count0);
         K_FETCH0: v = 64'(fetch_count0);
         K_PROTO0: v = 64'(proto_err0);
         K_EXEC0:  v = 64'(exec_complete0);
         default:  v = '0;
      endcase
      return v;
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_DRST:   return "dut_reset";
         K_INSTR:  return "instr_count";
         K_FETCH:  return "fetch_count";
         K_PROTO:  return "proto_err";
         K_EXEC:   return "exec_complete";
         K_RD1:    return "rf_rdata_lat1";
         K_RD0:    return "rf_rdata_lat0";
         K_DRST0:  return "dut_reset_lat0";
         K_INSTR0: return "instr_count_lat0";
         K_FETCH0: return "fetch_count_lat0";
         K_PROTO0: return "proto_err_lat0";
         K_EXEC0:  return "exec_complete_lat0";
         default:  return "unknown";
      endcase
   endfunction

   // Monitor: sole owner of total/bad.
   always @(negedge clock) begin : mon
      exec_exp_t   ex;
      logic [63:0] act;
      if (exec_complete) begin
         total++;
         if (exec_q.size() == 0) begin
            bad++;
            $display("FAIL exec_pulse: unexpected pulse at cycle %0d, required none", cyc);
         end else begin
            ex = exec_q.pop_front();
            if (ex.cyc != cyc || instr_count != ex.cnt) begin
               bad++;
               $display("FAIL exec_pulse: got cycle %0d instr_count %0d, required cycle %0d instr_count %0d",
                        cyc, instr_count, ex.cyc, ex.cnt);
            end
         end
      end else if (exec_q.size() != 0 && exec_q[0].cyc <= cyc) begin
         total++;
         bad++;
         ex = exec_q.pop_front();
         $display("FAIL exec_pulse: no pulse at cycle %0d, required pulse at cycle %0d", cyc, ex.cyc);
      end

      for (int i = chk_q.size() - 1; i >= 0; i--) begin
         if (chk_q[i].cyc <= cyc) begin
            total++;
            act = sample(chk_q[i].kind);
            if (chk_q[i].cyc != cyc || act !== chk_q[i].val) begin
               bad++;
               $display("FAIL %s @%0d: got %0h (sampled cycle %0d), required %0h",
                        kname(chk_q[i].kind), chk_q[i].cyc, act, cyc, chk_q[i].val);
            end
            chk_q.delete(i);
         end
      end

      if (done) begin
         total++;
         if (exec_q.size() != 0 || chk_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations: pending exec=%0d chk=%0d, required 0",
                     exec_q.size(), chk_q.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_at(input int k, input int at, input logic [63:0] v);
      chk_q.push_back('{kind: k, cyc: at, val: v});
   endtask

   // One op accepted in IDLE at the current cycle; returns in the next IDLE.
   task automatic do_op(input bit drop, input bit poke, input bit fetch_ack);
      int t;
      t = cyc;
      decode_valid = 1'b1;
      exec_q.push_back('{cyc: t + EXEC_LAT, cnt: exp_instr});
      tick();
      if (drop) begin
         decode_valid = 1'b0;
         expect_at(K_PROTO, t + 1, 64'd0);
         expect_at(K_PROTO, t + 2, 64'd1);
      end
      repeat (EXEC_LAT - 1) tick();
      decode_valid = 1'b0;
      if (fetch_ack) begin
         fetch_valid     = 1'b1;
         decode_complete = 1'b1;
         exp_fetch++;
      end
      exp_instr++;
      expect_at(K_INSTR, t + EXEC_LAT + 1, 64'(exp_instr));
      expect_at(K_FETCH, t + EXEC_LAT + 1, 64'(exp_fetch));
      tick();
      fetch_valid     = 1'b0;
      decode_complete = 1'b0;
      if (poke) decode_valid = 1'b1;
      tick();
      decode_valid = 1'b0;
   endtask

   logic [NP*RADDR_W-1:0] rd_vec [4];
   logic [NP*XLEN-1:0]    rd_exp [4];

   initial begin
      int c;
      rd_vec[0] = {6'd5,  6'd3};   rd_exp[0] = {32'd5,  32'd3};
      rd_vec[1] = {6'd63, 6'd0};   rd_exp[1] = {32'd63, 32'd0};
      rd_vec[2] = {6'd1,  6'd42};  rd_exp[2] = {32'd1,  32'd42};
      rd_vec[3] = {6'd21, 6'd63};  rd_exp[3] = {32'd21, 32'd63};

      reset = 1'b0; fetch_valid = 1'b0; decode_complete = 1'b0;
      decode_valid = 1'b0; rf_raddr = '0;

      // Reset state
      repeat (3) tick();
      expect_at(K_DRST,  cyc, 64'd1);  expect_at(K_INSTR, cyc, 64'd0);
      expect_at(K_FETCH, cyc, 64'd0);  expect_at(K_PROTO, cyc, 64'd0);
      expect_at(K_EXEC,  cyc, 64'd0);  expect_at(K_RD1,   cyc, 64'd0);
      expect_at(K_RD0,   cyc, 64'd0);  expect_at(K_DRST0, cyc, 64'd1);
      tick();

      // Release: dut_reset high for exactly RST_CYC clocks; checks disabled.
      reset = 1'b1;
      c = cyc;
      decode_valid = 1'b1; decode_complete = 1'b1; fetch_valid = 1'b0;
      expect_at(K_DRST, c, 64'd1);  expect_at(K_DRST, c + 1, 64'd1);
      expect_at(K_DRST, c + 2, 64'd0);
      expect_at(K_DRST0, c + 1, 64'd1); expect_at(K_DRST0, c + 2, 64'd0);
      tick();
      fetch_valid = 1'b1;
      tick();
      decode_valid = 1'b0; decode_complete = 1'b0; fetch_valid = 1'b0;
      expect_at(K_PROTO, c + 2, 64'd0); expect_at(K_PROTO, c + 3, 64'd0);
      expect_at(K_FETCH, c + 3, 64'd0); expect_at(K_INSTR, c + 3, 64'd0);
      tick();

      // Register read data: latency 1 and combinational
      for (int i = 0; i < 4; i++) begin
         rf_raddr = rd_vec[i];
         expect_at(K_RD0, cyc, 64'(rd_exp[i]));
         expect_at(K_RD1, cyc + 1, 64'(rd_exp[i]));
         tick();
      end
      tick();

      // Single op, with decode_valid poked during DRAIN (must be ignored)
      do_op(1'b0, 1'b1, 1'b0);
      tick();
      expect_at(K_INSTR, cyc + 3, 64'(exp_instr));
      repeat (4) tick();

      // Five back-to-back ops; last one with a fetch accept during ACK
      for (int i = 0; i < 5; i++) begin
         do_op(1'b0, 1'b0, i == 4);
      end
      expect_at(K_INSTR, cyc, 64'd6);
      expect_at(K_PROTO, cyc, 64'd0);
      tick();

      // Fetch counting: 3 accepts, then fetch_valid without decode_complete
      c = cyc;
      fetch_valid = 1'b1; decode_complete = 1'b1;
      repeat (3) tick();
      decode_complete = 1'b0;
      exp_fetch = exp_fetch + 32'd3;
      expect_at(K_FETCH, c + 3, 64'(exp_fetch));
      tick();
      fetch_valid = 1'b0;
      expect_at(K_FETCH, c + 4, 64'(exp_fetch));
      expect_at(K_PROTO, c + 5, 64'd0);
      repeat (2) tick();

      // decode_valid withdrawn in BUSY: proto_err sets and sticks
      do_op(1'b1, 1'b0, 1'b0);
      expect_at(K_PROTO, cyc + 3, 64'd1);
      repeat (4) tick();

      // Reset asserted during BUSY: no pulse, everything cleared
      decode_valid = 1'b1;
      tick();
      reset = 1'b0;
      decode_valid = 1'b0;
      exp_instr = 32'd0; exp_fetch = 32'd0;
      expect_at(K_DRST, cyc, 64'd1);  expect_at(K_EXEC, cyc, 64'd0);
      expect_at(K_INSTR, cyc, 64'd0); expect_at(K_PROTO, cyc, 64'd0);
      expect_at(K_FETCH, cyc, 64'd0);
      repeat (3) tick();
      reset = 1'b1;
      c = cyc;
      expect_at(K_DRST, c + 1, 64'd1); expect_at(K_DRST, c + 2, 64'd0);
      repeat (2) tick();
      do_op(1'b0, 1'b0, 1'b0);
      expect_at(K_INSTR, cyc, 64'd1);
      tick();

      // decode_complete without fetch_valid
      c = cyc;
      decode_complete = 1'b1; fetch_valid = 1'b0;
      expect_at(K_PROTO, c, 64'd0);
      expect_at(K_PROTO, c + 1, 64'd1);
      tick();
      decode_complete = 1'b0;
      expect_at(K_FETCH, c + 2, 64'd0);
      expect_at(K_PROTO, c + 4, 64'd1);
      repeat (4) tick();

      // Idle second instance
      expect_at(K_INSTR0, cyc, 64'd0); expect_at(K_FETCH0, cyc, 64'd0);
      expect_at(K_PROTO0, cyc, 64'd0); expect_at(K_EXEC0, cyc, 64'd0);
      repeat (2) tick();
      done = 1'b1;
   end

endmodule
`default_nettype wire
